tinker_fetch_unit: RTL and testbench

TINKER_FETCH_UNIT -- requirements
Module: tinker_fetch_unit

---
 rtl/tinker_pkg.sv | 30 +++
 rtl/tinker_fetch_chk.sv | 12 +
 rtl/tinker_fetch_fifo.sv | 68 ++++++
 rtl/tinker_fetch_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_tinker_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker fetch front end.
package tinker_pkg;

  localparam int              INSTR_W          = 32;
  localparam int              ADDR_W           = 64;
  localparam logic [63:0]     RESET_PC_DEFAULT = 64'h2000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

  // 32-bit add that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/tinker_fetch_chk.sv
// Simulation checks for the fetch unit: the credit scheme must never
// let a response push into a full instruction queue.
module tinker_fetch_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/tinker_fetch_fifo.sv
// Instruction queue between the memory response path and decode.
// Power-of-two depth, so the pointers wrap on their own.
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  fetch_entry_t          wr_entry,
  output fetch_entry_t          rd_entry,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // a write into a full queue is dropped; a pop of an empty queue is ignored
  always_comb begin
    full      = (count_r == CNT_MAX);
    empty     = (count_r == {CNT_W{1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  // storage, pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  assign rd_entry = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches under a credit limit,
// queues returned words for decode, and squashes stale responses after a
// redirect. Optional statistics counters: define TINKER_FETCH_STATS_EN.
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc4
`ifdef TINKER_FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_dropped
`endif
);

  localparam int                CNT_W        = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP      = 64'd4;

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] fetch_pc_nxt_s;
  logic [ADDR_W-1:0] rsp_pc_r;
  logic [ADDR_W-1:0] rsp_pc_nxt_s;
  logic [CNT_W-1:0]  inflight_r;
  logic [CNT_W-1:0]  inflight_nxt_s;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  drop_nxt_s;
  logic [CNT_W-1:0]  q_count_s;
  logic [CNT_W:0]    credit_used_s;
  logic              q_full_s;
  logic              q_empty_s;
  logic              req_valid_s;
  logic              req_hs_s;
  logic              rsp_acc_s;
  logic              rsp_drop_s;
  logic              push_s;
  logic              pop_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      head_s;

  // pipeline state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // IDLE lasts one cycle; HALTED is only left through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // issue while running, with queue + in-flight below DEPTH and no redirect
  always_comb begin
    credit_used_s = {1'b0, q_count_s} + {1'b0, inflight_r};
    if ((state_r == RUN) && (credit_used_s < CREDIT_LIMIT) && !redirect_valid) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // per-cycle events; a response in a redirect cycle is never kept
  always_comb begin
    req_hs_s           = req_valid_s & imem_req_ready;
    rsp_acc_s          = imem_rsp_valid & (inflight_r != CNT_ZERO);
    push_s             = rsp_acc_s & (drop_cnt_r == CNT_ZERO) & ~redirect_valid;
    rsp_drop_s         = rsp_acc_s & ~push_s;
    pop_s              = ~q_empty_s & out_ready;
    push_entry_s.instr = imem_rsp_data;
    push_entry_s.pc4   = rsp_pc_r + PC_STEP;
  end

  // kept responses are sequential from the last redirect target, so
  // rsp_pc tracks the address of the next word that will be queued
  always_comb begin
    if (req_hs_s && !rsp_acc_s) begin
      inflight_nxt_s = inflight_r + CNT_ONE;
    end else if (!req_hs_s && rsp_acc_s) begin
      inflight_nxt_s = inflight_r - CNT_ONE;
    end else begin
      inflight_nxt_s = inflight_r;
    end
    if (redirect_valid) begin
      drop_nxt_s     = inflight_nxt_s;
      fetch_pc_nxt_s = redirect_pc;
      rsp_pc_nxt_s   = redirect_pc;
    end else begin
      if (rsp_drop_s) begin
        drop_nxt_s = drop_cnt_r - CNT_ONE;
      end else begin
        drop_nxt_s = drop_cnt_r;
      end
      if (req_hs_s) begin
        fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (push_s) begin
        rsp_pc_nxt_s = rsp_pc_r + PC_STEP;
      end else begin
        rsp_pc_nxt_s = rsp_pc_r;
      end
    end
  end

  // fetch/response pointers and credit counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      inflight_r <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      rsp_pc_r   <= rsp_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

  tinker_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (push_entry_s),
    .rd_entry (head_s),
    .full     (q_full_s),
    .empty    (q_empty_s),
    .count    (q_count_s)
  );

  tinker_fetch_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (q_full_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = ~q_empty_s;
  assign out_instr      = head_s.instr;
  assign out_pc4        = head_s.pc4;

`ifdef TINKER_FETCH_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_dropped_r;
  logic [31:0] flushed_s;
  logic [31:0] dropped_inc_s;

  // discarded responses plus queue entries thrown away by a flush
  always_comb begin
    if (redirect_valid) begin
      flushed_s = 32'(q_count_s) - 32'(pop_s);
    end else begin
      flushed_s = 32'd0;
    end
    dropped_inc_s = flushed_s + 32'(rsp_drop_s);
  end

  // saturating statistics, frozen once halted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_r <= 32'd0;
      stat_dropped_r <= 32'd0;
    end else if (state_r != HALTED) begin
      stat_fetched_r <= sat_add32(stat_fetched_r, 32'(push_s));
      stat_dropped_r <= sat_add32(stat_dropped_r, dropped_inc_s);
    end else begin
      stat_fetched_r <= stat_fetched_r;
      stat_dropped_r <= stat_dropped_r;
    end
  end

  assign stat_fetched = stat_fetched_r;
  assign stat_dropped = stat_dropped_r;
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit with an in-order memory model and
// a scoreboard of words expected at the decode port.
module tb_tinker_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [63:0] out_pc4;
`ifdef TINKER_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
`endif

  always #5 clk = ~clk;

  tinker_fetch_unit #(
    .RESET_PC (64'h2000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4)
`ifdef TINKER_FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped)
`endif
  );

  typedef struct { logic [63:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc4; } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          tick_no = 0;
  int          epoch = 0;
  int          lat = 1;
  int          hs_cnt = 0;
  int          pop_cnt = 0;
  int          push_cnt = 0;
  int          first_hs_tick = -1;
  int          first_valid_tick = -1;
  logic [63:0] first_hs_addr = 64'h0;
  logic [63:0] first_pop_pc4 = 64'h0;
  logic        have_pop = 1'b0;
  logic [63:0] exp_pc = 64'h2000;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_marks();
    first_hs_tick    = -1;
    first_valid_tick = -1;
    first_hs_addr    = 64'h0;
    first_pop_pc4    = 64'h0;
    have_pop         = 1'b0;
    hs_cnt           = 0;
    pop_cnt          = 0;
  endtask

  // one clock: present memory response, check outputs, update the model
  task automatic tick();
    logic        rsp;
    logic        hs;
    logic        pop;
    logic [63:0] addr;
    int          t0;
    mreq_t       m;
    t0  = tick_no;
    rsp = (memq.size() > 0) && (memq[0].due <= tick_no);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : 32'h0;
    #1;
    hs   = imem_req_valid && imem_req_ready;
    pop  = out_valid && out_ready;
    addr = imem_req_addr;
    check("out_valid", out_valid, expq.size() != 0);
    if (redirect_valid) check("req_on_redirect", imem_req_valid, 1'b0);
    if (hs) begin
      check("req_addr", addr, exp_pc);
      hs_cnt++;
      if (first_hs_tick < 0) begin
        first_hs_tick = t0;
        first_hs_addr = addr;
      end
    end
    if (out_valid && first_valid_tick < 0) first_valid_tick = t0;
    if (pop && expq.size() > 0) begin
      check("out_instr", out_instr, expq[0].instr);
      check("out_pc4", out_pc4, expq[0].pc4);
      if (!have_pop) begin
        first_pop_pc4 = out_pc4;
        have_pop = 1'b1;
      end
      pop_cnt++;
    end
    @(posedge clk);
    #1;
    tick_no++;
    if (pop && expq.size() > 0) void'(expq.pop_front());
    if (rsp) begin
      m = memq.pop_front();
      if (m.epoch == epoch && !redirect_valid) begin
        expq.push_back('{mem_word(m.addr), m.addr + 64'd4});
        push_cnt++;
      end
    end
    if (redirect_valid) begin
      expq.delete();
      epoch++;
      exp_pc = redirect_pc;
    end else if (hs) begin
      exp_pc = exp_pc + 64'd4;
    end
    if (hs) memq.push_back('{addr, t0 + lat, epoch});
  endtask

  // reset with junk responses on the bus, then check reset values
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc4", out_pc4, 64'h0);
`ifdef TINKER_FETCH_STATS_EN
    check("rst_stat_fetched", stat_fetched, 32'h0);
    check("rst_stat_dropped", stat_dropped, 32'h0);
`endif
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    memq.delete();
    expq.delete();
    exp_pc   = 64'h2000;
    epoch    = 0;
    tick_no  = 0;
    push_cnt = 0;
    clear_marks();
    reset = 1'b0;
    #1;
    check("idle_no_req", imem_req_valid, 1'b0);
  endtask

  initial begin
    // sequential fetch with a 1-cycle memory
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (20) tick();
    check("first_req_tick", first_hs_tick, 1);
    check("first_req_addr", first_hs_addr, 64'h2000);
    check("first_out_latency", first_valid_tick - first_hs_tick, 2);
    check("first_out_pc4", first_pop_pc4, 64'h2004);

    // credit limit with decode stalled
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (20) tick();
    check("credit_req_count", hs_cnt, 4);
    check("credit_blocked", imem_req_valid, 1'b0);
    check("credit_full_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    hs_cnt = 0;
    tick();
    out_ready = 1'b0;
    repeat (10) tick();
    check("credit_one_more", hs_cnt, 1);
    out_ready = 1'b1;
    repeat (15) tick();

    // redirect with three slow requests outstanding
    do_reset();
    lat = 5; imem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 3; i++) tick();
    check("three_outstanding", hs_cnt, 3);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    clear_marks();
    repeat (40) tick();
    check("redir_first_req", first_hs_addr, 64'h3000);
    check("redir_first_pc4", first_pop_pc4, 64'h3004);
`ifdef TINKER_FETCH_STATS_EN
    check("stat_dropped", stat_dropped, 32'd3);
    check("stat_fetched", stat_fetched, push_cnt);
`endif

    // redirect in a cycle that also carries a response
    do_reset();
    lat = 2; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    check("rsp_in_redirect_cycle", (memq.size() > 0) && (memq[0].due <= tick_no), 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    clear_marks();
    repeat (20) tick();
    check("redir_rsp_first_req", first_hs_addr, 64'h4000);
    check("redir_rsp_first_pc4", first_pop_pc4, 64'h4004);

    // halt with two in flight, redirect while halted
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10 && hs_cnt < 2; i++) tick();
    check("two_in_flight", hs_cnt, 2);
    imem_req_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0; imem_req_ready = 1'b1;
    clear_marks();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("halted_no_req", imem_req_valid, 1'b0);
    end
    check("halted_req_count", hs_cnt, 0);
    check("halted_delivered", pop_cnt, 2);
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check("halted_redirect_no_req", hs_cnt, 0);

    // reset in the middle of a stream restarts at RESET_PC
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (6) tick();
    do_reset();
    repeat (8) tick();
    check("restart_addr", first_hs_addr, 64'h2000);
    check("restart_pc4", first_pop_pc4, 64'h2004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
